// File: rtl/trsq_pkg.sv
// trsq_pkg: shared PC-source encoding, default parameters and vector-address helper.
package trsq_pkg;
    localparam int PC_W_DEF        = 13;
    localparam int STACK_DEPTH_DEF = 4;
    localparam int N_IRQ_DEF       = 4;
    localparam int VEC_BASE_DEF    = 4;
    localparam int VEC_STRIDE_DEF  = 4;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_SKIP,
        PC_JMP,
        PC_CALL,
        PC_RET,
        PC_VEC
    } pc_src_e;

    function automatic int unsigned vec_addr(input int unsigned base, input int unsigned stride,
                                             input int unsigned idx);
        return base + idx * stride;
    endfunction
endpackage

// File: rtl/ret_stack.sv
// ret_stack: parametrised return-address LIFO with sticky overflow/underflow flags.
module ret_stack #(
    parameter int W     = 13,
    parameter int DEPTH = 4,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_ip,
    input  logic          reset_n_ip,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    input  logic          clr_err,
    output logic [W-1:0]  top,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] depth,
    output logic          ovf,
    output logic          unf
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];

    assign full  = depth == DW'(DEPTH);
    assign empty = depth == '0;
    assign top   = empty ? '0 : mem[AW'(depth - DW'(1))];

    always_ff @(posedge clk_ip)
        if (push && !full) mem[AW'(depth)] <= push_data;

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_ip or negedge reset_n_ip)
        if (!reset_n_ip) begin
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            depth <= push && !full ? depth + DW'(1) : pop && !empty ? depth - DW'(1) : depth;
            ovf   <= push && full ? 1'b1 : clr_err ? 1'b0 : ovf;
            unf   <= pop && empty ? 1'b1 : clr_err ? 1'b0 : unf;
        end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, return stack and prioritised vectored interrupt controller.
module pc_sequencer
    import trsq_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int N_IRQ       = N_IRQ_DEF,
    parameter int VEC_BASE    = VEC_BASE_DEF,
    parameter int VEC_STRIDE  = VEC_STRIDE_DEF,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk_ip,
    input  logic             reset_n_ip,
    input  logic             jmp_ip,
    input  logic             call_ip,
    input  logic             ret_ip,
    input  logic             reti_ip,
    input  logic             skip_ip,
    input  logic             halt_ip,
    input  logic [PC_W-1:0]  tgt_ip,
    input  logic [N_IRQ-1:0] irq_ip,
    input  logic             ien_wr_ip,
    input  logic [N_IRQ:0]   ien_data_ip,
    input  logic             clr_err_ip,
    output logic [PC_W-1:0]  pc_op,
    output logic             irq_take_op,
    output logic [N_IRQ-1:0] irq_ack_op,
    output logic [N_IRQ-1:0] pending_op,
    output logic [N_IRQ:0]   ien_op,
    output logic [DW-1:0]    depth_op,
    output logic             halted_op,
    output logic             ovf_op,
    output logic             unf_op
);
    logic [PC_W-1:0]  pc_nxt, top, push_data, vec;
    logic [N_IRQ-1:0] s1, s2, s3, en, qual, win, edges;
    logic             gie, take, push, pop, set_gie, full, empty;
    pc_src_e          src;

    ret_stack #(.W(PC_W), .DEPTH(STACK_DEPTH), .DW(DW)) u_stack (
        .clk_ip    (clk_ip),
        .reset_n_ip(reset_n_ip),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clr_err   (clr_err_ip),
        .top       (top),
        .full      (full),
        .empty     (empty),
        .depth     (depth_op),
        .ovf       (ovf_op),
        .unf       (unf_op)
    );

    assign edges       = s2 & ~s3;
    assign ien_op      = {gie, en};
    assign irq_take_op = take;

    // Lowest pending-and-enabled channel wins; the vector loop walks down so index 0 lands last.
    always_comb begin
        qual = pending_op & en;
        win  = qual & (~qual + N_IRQ'(1));
        take = gie & |qual & ~full;
        vec  = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (qual[i]) vec = PC_W'(vec_addr(VEC_BASE, VEC_STRIDE, i));
        src = take ? PC_VEC : (halted_op | halt_ip) ? PC_HOLD : jmp_ip ? PC_JMP :
              call_ip ? PC_CALL : (ret_ip | reti_ip) ? PC_RET : skip_ip ? PC_SKIP : PC_INC;
        set_gie   = src == PC_RET && !ret_ip;
        push      = src == PC_VEC || src == PC_CALL;
        pop       = src == PC_RET;
        push_data = take ? pc_op : pc_op + PC_W'(1);
        pc_nxt = src == PC_VEC ? vec :
                 src == PC_HOLD ? pc_op :
                 (src == PC_JMP || src == PC_CALL) ? tgt_ip :
                 (src == PC_RET && !empty) ? top :
                 src == PC_SKIP ? pc_op + PC_W'(2) : pc_op + PC_W'(1);
    end

    always_ff @(posedge clk_ip or negedge reset_n_ip)
        if (!reset_n_ip) begin
            {s3, s2, s1} <= '0;
            pending_op   <= '0;
            irq_ack_op   <= '0;
            en           <= '0;
            gie          <= 1'b0;
            halted_op    <= 1'b0;
            pc_op        <= '0;
        end else begin
            {s3, s2, s1} <= {s2, s1, irq_ip};
            pending_op   <= (pending_op & ~(take ? win : '0)) | edges;
            irq_ack_op   <= take ? win : '0;
            en           <= ien_wr_ip ? ien_data_ip[N_IRQ-1:0] : en;
            gie          <= take ? 1'b0 : set_gie ? 1'b1 : ien_wr_ip ? ien_data_ip[N_IRQ] : gie;
            halted_op    <= take ? 1'b0 : halted_op | halt_ip;
            pc_op        <= pc_nxt;
        end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of PC flow, return stack, interrupts and halt.
module tb_pc_sequencer;
    logic        clk_ip = 1'b0, reset_n_ip = 1'b0;
    logic        jmp_ip = 0, call_ip = 0, ret_ip = 0, reti_ip = 0, skip_ip = 0, halt_ip = 0;
    logic [12:0] tgt_ip = '0;
    logic [3:0]  irq_ip = '0;
    logic        ien_wr_ip = 0, clr_err_ip = 0;
    logic [4:0]  ien_data_ip = '0;
    logic [12:0] pc_op;
    logic        irq_take_op, halted_op, ovf_op, unf_op;
    logic [3:0]  irq_ack_op, pending_op;
    logic [4:0]  ien_op;
    logic [2:0]  depth_op;
    int checks = 0, errors = 0;

    pc_sequencer dut (
        .clk_ip(clk_ip), .reset_n_ip(reset_n_ip), .jmp_ip(jmp_ip), .call_ip(call_ip),
        .ret_ip(ret_ip), .reti_ip(reti_ip), .skip_ip(skip_ip), .halt_ip(halt_ip),
        .tgt_ip(tgt_ip), .irq_ip(irq_ip), .ien_wr_ip(ien_wr_ip), .ien_data_ip(ien_data_ip),
        .clr_err_ip(clr_err_ip), .pc_op(pc_op), .irq_take_op(irq_take_op),
        .irq_ack_op(irq_ack_op), .pending_op(pending_op), .ien_op(ien_op),
        .depth_op(depth_op), .halted_op(halted_op), .ovf_op(ovf_op), .unf_op(unf_op)
    );

    always #5 clk_ip = ~clk_ip;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_ip);
        #1;
        {jmp_ip, call_ip, ret_ip, reti_ip, skip_ip, halt_ip, ien_wr_ip, clr_err_ip} = '0;
        irq_ip = '0;
    endtask

    initial begin
        repeat (2) @(posedge clk_ip);
        #1;
        chk("rst_pc", pc_op, 0);
        chk("rst_ien", ien_op, 0);
        chk("rst_pend", pending_op, 0);
        chk("rst_misc", {depth_op, halted_op, ovf_op, unf_op, irq_ack_op}, 0);
        reset_n_ip = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("idle_pc", pc_op, i);
        end
        chk("idle_depth", depth_op, 0);
        // call / ret
        jmp_ip = 1; tgt_ip = 13'h010; cyc();
        chk("jmp_pc", pc_op, 13'h010);
        call_ip = 1; tgt_ip = 13'h100; cyc();
        chk("call_pc", pc_op, 13'h100);
        chk("call_depth", depth_op, 1);
        ret_ip = 1; cyc();
        chk("ret_pc", pc_op, 13'h011);
        chk("ret_depth", depth_op, 0);
        // two simultaneous IRQs, lowest channel first
        jmp_ip = 1; tgt_ip = 13'h01E; ien_wr_ip = 1; ien_data_ip = 5'b1_0110; irq_ip = 4'b0110; cyc();
        chk("irq_ien", ien_op, 5'b1_0110);
        cyc();
        chk("irq_pend_early", pending_op, 0);
        cyc();
        chk("irq_pc_before", pc_op, 13'h020);
        chk("irq_pend", pending_op, 4'b0110);
        chk("irq_take", irq_take_op, 1);
        cyc();
        chk("take1_pc", pc_op, 13'h008);
        chk("take1_ack", irq_ack_op, 4'b0010);
        chk("take1_pend", pending_op, 4'b0100);
        chk("take1_ien", ien_op, 5'b0_0110);
        chk("take1_depth", depth_op, 1);
        reti_ip = 1; cyc();
        chk("reti1_pc", pc_op, 13'h020);
        chk("reti1_ien", ien_op, 5'b1_0110);
        chk("reti1_ack", irq_ack_op, 0);
        cyc();
        chk("take2_pc", pc_op, 13'h00C);
        chk("take2_ack", irq_ack_op, 4'b0100);
        reti_ip = 1; cyc();
        chk("reti2_pc", pc_op, 13'h020);
        chk("reti2_pend", pending_op, 0);
        // overflow / underflow
        call_ip = 1; tgt_ip = 13'h040; cyc();
        for (int i = 1; i <= 4; i++) begin
            call_ip = 1; tgt_ip = 13'h040 + 13'(i); cyc();
        end
        chk("ovf_pc", pc_op, 13'h044);
        chk("ovf_depth", depth_op, 4);
        chk("ovf_flag", {ovf_op, unf_op}, 2'b10);
        ret_ip = 1; cyc();
        chk("pop1_pc", pc_op, 13'h043);
        ret_ip = 1; cyc();
        ret_ip = 1; cyc();
        chk("pop3_pc", pc_op, 13'h041);
        ret_ip = 1; cyc();
        chk("pop4_pc", pc_op, 13'h021);
        chk("pop4_depth", depth_op, 0);
        ret_ip = 1; cyc();
        chk("unf_pc", pc_op, 13'h022);
        chk("unf_flags", {ovf_op, unf_op}, 2'b11);
        clr_err_ip = 1; cyc();
        chk("clr_flags", {ovf_op, unf_op}, 2'b00);
        chk("clr_pc", pc_op, 13'h023);
        ret_ip = 1; clr_err_ip = 1; cyc();
        chk("clr_vs_err", {ovf_op, unf_op}, 2'b01);
        skip_ip = 1; cyc();
        chk("skip_pc", pc_op, 13'h026);
        jmp_ip = 1; tgt_ip = 13'h1FFF; cyc();
        skip_ip = 1; cyc();
        chk("wrap_pc", pc_op, 13'h0001);
        // halt and wake
        jmp_ip = 1; tgt_ip = 13'h030; cyc();
        halt_ip = 1; cyc();
        chk("halt_flag", halted_op, 1);
        repeat (10) cyc();
        chk("halt_pc", pc_op, 13'h030);
        ien_wr_ip = 1; ien_data_ip = 5'b1_0001; irq_ip = 4'b0001; cyc();
        cyc();
        cyc();
        chk("halt_pend", {pending_op, irq_take_op, halted_op}, 6'b0001_1_1);
        chk("halt_pc2", pc_op, 13'h030);
        cyc();
        chk("wake_pc", pc_op, 13'h004);
        chk("wake_halted", halted_op, 0);
        chk("wake_ack", irq_ack_op, 4'b0001);
        reti_ip = 1; cyc();
        chk("wake_reti_pc", pc_op, 13'h030);
        // full stack blocks take
        for (int i = 0; i < 4; i++) begin
            call_ip = 1; tgt_ip = 13'h050 + 13'(i); cyc();
        end
        chk("full_depth", depth_op, 4);
        chk("full_pc", pc_op, 13'h053);
        irq_ip = 4'b0001; cyc();
        cyc();
        cyc();
        chk("full_pend", pending_op, 4'b0001);
        chk("full_notake", irq_take_op, 0);
        cyc();
        chk("full_hold", {pending_op, irq_take_op}, 5'b0001_0);
        chk("full_pc2", pc_op, 13'h057);
        ret_ip = 1; cyc();
        chk("unblock_pc", pc_op, 13'h053);
        chk("unblock_take", irq_take_op, 1);
        cyc();
        chk("late_take_pc", pc_op, 13'h004);
        chk("late_take_depth", depth_op, 4);
        chk("late_take_pend", pending_op, 0);
        // asynchronous mid-cycle reset
        #2 reset_n_ip = 1'b0;
        #1;
        chk("async_rst", {pc_op, depth_op, pending_op, ien_op, irq_ack_op}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-flow unit for the next TRSQ core generation. It holds the program counter, a multi-level return-address stack for `call`/`ret`/`reti`, and a prioritised, maskable, vectored interrupt controller with `N_IRQ` channels. It sits between the instruction decoder and the program ROM address bus. It replaces the single-level, single-IRQ PC logic of the current core and moves PC updates onto the rising edge.

## Interface
- `PC_W`, 13: PC / ROM address width.
- `STACK_DEPTH`, 4: return-stack entries (≥1).
- `N_IRQ`, 4: interrupt channels (1–8).
- `VEC_BASE`, 4: vector address of channel 0.
- `VEC_STRIDE`, 4: address spacing between vectors.

Ports:
- `clk_ip`  in  1  sole clock, rising edge.
- `reset_n_ip`  in  1  asynchronous, active-low reset.
- `jmp_ip`  in  1  decoded jump.
- `call_ip`  in  1  decoded call.
- `ret_ip`  in  1  decoded return.
- `reti_ip`  in  1  decoded return-from-interrupt.
- `skip_ip`  in  1  skip condition true (already qualified with flags).
- `halt_ip`  in  1  decoded halt.
- `tgt_ip`  in  PC_W  jump/call target.
- `irq_ip`  in  N_IRQ  asynchronous interrupt requests, rising-edge triggered.
- `ien_wr_ip`  in  1  write strobe for enable mask.
- `ien_data_ip`  in  N_IRQ+1  {GIE, per-channel enables}.
- `clr_err_ip`  in  1  clears sticky error flags.
- `pc_op`  out  PC_W  ROM address.
- `irq_take_op`  out  1  combinational; current instruction is squashed this cycle.
- `irq_ack_op`  out  N_IRQ  one-hot, one-cycle pulse on take.
- `pending_op`  out  N_IRQ  pending flags.
- `ien_op`  out  N_IRQ+1  current {GIE, enables}.
- `depth_op`  out  clog2(STACK_DEPTH+1)  stack occupancy.
- `halted_op`  out  1  core halted.
- `ovf_op`, `unf_op`  out  1  sticky stack overflow / underflow.

## Operation
- **Reset:** `pc_op`=0, GIE=0, enables=0, pending=0, depth=0, `halted_op`=0, `ovf_op`=`unf_op`=0, `irq_ack_op`=0.
- **IRQ input path:** each `irq_ip` bit passes a 2-FF synchroniser, then a rising-edge detector. A detected edge sets `pending[i]`.
- **Take condition:** take = GIE & |(pending & enables) & depth<STACK_DEPTH. The winning channel is the lowest set index.
- **On take:**
  - push the current `pc_op`;
  - `pc_op` ← VEC_BASE + idx·VEC_STRIDE (truncated to PC_W);
  - clear `pending[idx]` and GIE;
  - pulse `irq_ack_op[idx]`;
  - clear `halted_op`;
  - ignore all instruction inputs that cycle.
- **Otherwise, first match among instruction inputs:**
  1. `halted_op`=1: hold.
  2. `halt_ip`: set `halted_op`, hold PC.
  3. `jmp_ip`: PC ← `tgt_ip`.
  4. `call_ip`: push PC+1, PC ← `tgt_ip`.
  5. `ret_ip`: pop to PC.
  6. `reti_ip`: pop to PC, GIE ← 1.
  7. `skip_ip`: PC+2.
  8. Default: PC+1.
- **Arithmetic:** all PC math is modulo 2^PC_W (wraps).
- **Push when full:** only possible via `call`. Set `ovf_op`, drop the push, keep the stack contents; the jump still happens.
- **Pop when empty:** set `unf_op`, PC ← PC+1, GIE still set by `reti`.
- **Simultaneous edge and take on the same channel:** pending stays set (set wins).
- **`ien_wr_ip`:** loads the mask at the clock edge. If it coincides with a take, the take's GIE clear wins over the written GIE; the written channel enables still apply.
- **`clr_err_ip`:** clears both sticky flags. A coincident new error wins.

## Timing
- Registered outputs: all except `irq_take_op`, which is combinational from registered state.
- **PC update:** one cycle after the controlling input is sampled. Instruction inputs must be decoded from the ROM data at the current `pc_op` within the same cycle; the ROM is asynchronous-read.
- **IRQ latency:** edge on `irq_ip` → `pending_op` after 3 clocks. Take occurs on the following edge if qualified.
- **Wake from halt:** `halted_op` falls on the same edge that loads the vector.
- **Mid-operation reset:** asynchronous assertion forces all reset values immediately; release is synchronous in effect on the next edge.

## Structure
- Shared package `trsq_pkg` holds:
  - the PC-source encoding enum (HOLD, INC, SKIP, JMP, CALL, RET, VEC);
  - the default parameter constants;
  - a vector-address function.
- One sub-module, `ret_stack`: a parametrised LIFO with push/pop/full/empty/depth and ovf/unf detection.
- Synchroniser and edge detectors stay inline.

## Test plan
- Reset, then 5 idle cycles → `pc_op` = 0,1,2,3,4,5; `depth_op`=0.
- PC=0x10, `call_ip` with `tgt_ip`=0x100, then `ret_ip` at 0x100 → PC=0x100, depth=1, then PC=0x11, depth=0.
- `ien`=0b1_0110, pulse `irq_ip`=0b0110 together at PC=0x20 → take channel 1: PC=0x08, ack=0b0010. `reti` → PC=0x20 (0x20 re-executed). Next take is channel 2: PC=0x0C.
- STACK_DEPTH=4, five nested calls → `ovf_op`=1 after the 5th, depth=4. Then five rets → 5th sets `unf_op`. `clr_err_ip` clears both.
- `halt_ip` at PC=0x30, then 10 cycles → PC holds 0x30. `irq_ip[0]` with GIE → PC=0x04, `halted_op`=0. `reti` → 0x30.
- Stack full (4 entries), channel 0 pending and enabled → no take, pending held. After one `ret` → take on the next cycle.
